// File: rtl/qerv_pcgen.sv
// Bit-serial program counter: updates the PC one W-bit beat per cycle, then
// requests an instruction fetch from the new address.
module qerv_pcgen #(
    parameter int          W        = 4,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter bit          WITH_CSR = 1'b1,
    parameter bit          WITH_C   = 1'b0,
    localparam int         N        = 32 / W,
    localparam int         BW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_pc_start,
    input  logic          i_jump,
    input  logic          i_jal_or_jalr,
    input  logic          i_utype,
    input  logic          i_pc_rel,
    input  logic          i_trap,
    input  logic          i_iscomp,
    input  logic [W-1:0]  i_imm,
    input  logic [W-1:0]  i_buf,
    input  logic [W-1:0]  i_csr_pc,
    output logic [W-1:0]  o_rd,
    output logic [W-1:0]  o_bad_pc,
    output logic [BW-1:0] o_beat,
    output logic          o_busy,
    output logic          o_misalign,
    output logic [31:0]   o_ibus_adr,
    output logic          o_ibus_cyc,
    input  logic          i_ibus_ack,
    output logic [1:0]    o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_FETCH = 2'd2} state_t;

    // Target bit 1 lives in beat 1 bit 0 when W=1, otherwise in beat 0 bit 1.
    localparam int MIS_BEAT = (W == 1) ? 1 : 0;
    localparam int MIS_BIT  = (W == 1) ? 0 : 1;

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          carry_4_q, carry_4_d;
    logic          carry_off_q, carry_off_d;
    logic          mis_bit_q, mis_bit_d;
    logic          misalign_q, misalign_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;

    logic          first_beat, last_beat, trap_eff, mis_check;
    logic          cin_4, cin_off;
    logic [31:0]   c_word;
    logic [W-1:0]  pc_beat, c_beat, imm_mask, csr_mask, off_a, off_b;
    logic [W:0]    sum_4, sum_off;
    logic [W-1:0]  target, new_pc;

    always_comb begin
        first_beat = (cnt_q == '0);
        last_beat  = (cnt_q == BW'(N - 1));
        trap_eff   = WITH_CSR && i_trap;
        mis_check  = !WITH_C && i_jump && !trap_eff;
        pc_beat    = adr_q[W-1:0];
        c_word     = i_iscomp ? 32'd2 : 32'd4;
        c_beat     = W'(c_word >> (32'(cnt_q) * W));
        for (int i = 0; i < W; i++) begin
            imm_mask[i] = (int'(cnt_q) * W + i) >= 12;
            csr_mask[i] = (int'(cnt_q) * W + i) >= 2;
        end
        // Carries from a previous operation never leak into beat 0.
        cin_4   = first_beat ? 1'b0 : carry_4_q;
        cin_off = first_beat ? 1'b0 : carry_off_q;
        off_a   = i_pc_rel ? pc_beat : '0;
        off_b   = i_utype ? (i_imm & imm_mask) : i_buf;
        sum_4   = {1'b0, pc_beat} + {1'b0, c_beat} + (W+1)'(cin_4);
        sum_off = {1'b0, off_a} + {1'b0, off_b} + (W+1)'(cin_off);
        target  = sum_off[W-1:0];
        if (first_beat) target[0] = 1'b0;
        new_pc  = trap_eff ? (i_csr_pc & csr_mask) : (i_jump ? target : sum_4[W-1:0]);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_4_d   = carry_4_q;
        carry_off_d = carry_off_q;
        mis_bit_d   = mis_bit_q;
        misalign_d  = 1'b0;
        adr_d       = adr_q;
        o_rd        = '0;
        o_bad_pc    = '0;
        case (state_q)
            S_IDLE: begin
                if (i_pc_start) begin
                    state_d   = S_SHIFT;
                    cnt_d     = '0;
                    mis_bit_d = 1'b0;
                end
            end
            S_SHIFT: begin
                o_rd        = (i_utype ? target : '0) | (i_jal_or_jalr ? sum_4[W-1:0] : '0);
                o_bad_pc    = target;
                adr_d       = {new_pc, adr_q[31:W]};
                carry_4_d   = sum_4[W];
                carry_off_d = sum_off[W];
                if (mis_check && cnt_q == BW'(MIS_BEAT)) mis_bit_d = target[MIS_BIT];
                if (last_beat) begin
                    state_d    = S_FETCH;
                    cnt_d      = '0;
                    misalign_d = mis_bit_d;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            S_FETCH: begin
                if (cyc_q && i_ibus_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so that reset leaves the bus idle until the first edge.
        cyc_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            carry_4_q   <= 1'b0;
            carry_off_q <= 1'b0;
            mis_bit_q   <= 1'b0;
            misalign_q  <= 1'b0;
            cyc_q       <= 1'b0;
            adr_q       <= RESET_PC;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_4_q   <= carry_4_d;
            carry_off_q <= carry_off_d;
            mis_bit_q   <= mis_bit_d;
            misalign_q  <= misalign_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
        end
    end

    assign o_beat      = cnt_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_misalign  = misalign_q;
    assign o_ibus_adr  = adr_q;
    assign o_ibus_cyc  = cyc_q;
    assign o_dbg_state = state_q;
endmodule

// File: tb/tb_qerv_pcgen.sv
// Directed bench for qerv_pcgen: a W=4 instance under full control plus
// W=1/2/8 instances fed the same operations and expected to agree on the PC.
module tb_qerv_pcgen;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, poke = 1'b0, ack4 = 1'b0;
    logic jump = 0, jal = 0, utype = 0, pc_rel = 0, trap = 0, iscomp = 0;
    logic [31:0] imm32 = '0, buf32 = '0, csr32 = '0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    logic [3:0]  imm4, buf4, csr4, rd4, bad4;
    logic [2:0]  beat4;
    logic        busy4, mis4, cyc4;
    logic [31:0] adr4;
    logic [1:0]  st4;
    logic [31:0] alt_adr [3];
    logic [2:0]  alt_busy;

    assign imm4 = imm32[int'(beat4)*4 +: 4];
    assign buf4 = buf32[int'(beat4)*4 +: 4];
    assign csr4 = csr32[int'(beat4)*4 +: 4];

    qerv_pcgen #(.W(4), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .i_rst_n(rst_n), .i_pc_start(start | poke),
        .i_jump(jump), .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pc_rel),
        .i_trap(trap), .i_iscomp(iscomp), .i_imm(imm4), .i_buf(buf4), .i_csr_pc(csr4),
        .o_rd(rd4), .o_bad_pc(bad4), .o_beat(beat4), .o_busy(busy4), .o_misalign(mis4),
        .o_ibus_adr(adr4), .o_ibus_cyc(cyc4), .i_ibus_ack(ack4), .o_dbg_state(st4)
    );

    for (genvar g = 0; g < 3; g++) begin : g_alt
        localparam int WX = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        localparam int BX = $clog2(32 / WX);
        logic [BX-1:0] beat;
        logic [WX-1:0] rd, bpc, imm_b, buf_b, csr_b;
        logic          busy, mis, cyc;
        logic [31:0]   adr;
        logic [1:0]    st;
        assign imm_b = imm32[int'(beat)*WX +: WX];
        assign buf_b = buf32[int'(beat)*WX +: WX];
        assign csr_b = csr32[int'(beat)*WX +: WX];
        qerv_pcgen #(.W(WX), .RESET_PC(RST_PC)) u_alt (
            .clk(clk), .i_rst_n(rst_n), .i_pc_start(start),
            .i_jump(jump), .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pc_rel),
            .i_trap(trap), .i_iscomp(iscomp), .i_imm(imm_b), .i_buf(buf_b), .i_csr_pc(csr_b),
            .o_rd(rd), .o_bad_pc(bpc), .o_beat(beat), .o_busy(busy), .o_misalign(mis),
            .o_ibus_adr(adr), .o_ibus_cyc(cyc), .i_ibus_ack(cyc), .o_dbg_state(st)
        );
        assign alt_adr[g]  = adr;
        assign alt_busy[g] = busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy4 || alt_busy != 3'b000) && n < 200) begin
            ack4 = cyc4;
            @(negedge clk);
            n++;
        end
        ack4 = 1'b0;
        chk({tag, "_idle_timeout"}, 32'(n < 200), 32'd1);
    endtask

    task automatic run_op(input string tag, input bit j, input bit jl, input bit ut, input bit rel,
                          input bit tr, input bit cp, input logic [31:0] im, input logic [31:0] bf,
                          input logic [31:0] cs, input int hold, input bit pk,
                          input logic [31:0] e_pc, input logic [31:0] e_rd,
                          input logic [31:0] e_bad, input bit e_mis);
        int n = 0, mis_n = 0, mis_at = -1, fetch_at = -1, hold_left = hold;
        logic [31:0] rd_acc = '0, bad_acc = '0;
        bit done = 0;
        @(negedge clk);
        jump = j; jal = jl; utype = ut; pc_rel = rel; trap = tr; iscomp = cp;
        imm32 = im; buf32 = bf; csr32 = cs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 200) begin
            if (st4 == 2'd1) begin
                rd_acc[int'(beat4)*4 +: 4]  = rd4;
                bad_acc[int'(beat4)*4 +: 4] = bad4;
            end
            if (mis4) begin mis_n++; mis_at = n; end
            if (cyc4 && fetch_at < 0) fetch_at = n;
            poke = pk && (n == 3 || (cyc4 && hold_left == 2));
            if (cyc4 && hold_left > 0) begin
                chk({tag, "_hold_adr"}, adr4, e_pc);
                chk({tag, "_hold_cyc"}, 32'(cyc4), 32'd1);
                hold_left--;
                ack4 = 1'b0;
            end else begin
                ack4 = cyc4;
            end
            @(negedge clk);
            n++;
            done = !busy4 && alt_busy == 3'b000;
        end
        ack4 = 1'b0;
        poke = 1'b0;
        chk({tag, "_timeout"}, 32'(done), 32'd1);
        chk({tag, "_pc"}, adr4, e_pc);
        for (int k = 0; k < 3; k++) chk({tag, "_pc_alt"}, alt_adr[k], e_pc);
        chk({tag, "_rd"}, rd_acc, e_rd);
        chk({tag, "_bad_pc"}, bad_acc, e_bad);
        chk({tag, "_mis_cnt"}, 32'(mis_n), 32'(e_mis));
        if (e_mis) chk({tag, "_mis_cycle"}, 32'(mis_at), 32'(fetch_at));
        chk({tag, "_rd_idle"}, 32'(rd4), 32'd0);
        chk({tag, "_cyc_idle"}, 32'(cyc4), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_adr", adr4, RST_PC);
        chk("rst_cyc", 32'(cyc4), 32'd0);
        chk("rst_beat", 32'(beat4), 32'd0);
        chk("rst_mis", 32'(mis4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cyc", 32'(cyc4), 32'd1);
        chk("rel_adr", adr4, RST_PC);
        wait_idle("boot");

        //     tag          j  jl ut rl tr cp imm            buf            csr            hold pk pc             rd             bad            mis
        run_op("jmp100",    1, 0, 0, 0, 0, 0, 32'h0,         32'h100,       32'h0,         0, 0, 32'h100,       32'h0,         32'h100,       0);
        run_op("plus4",     0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 32'h104,       32'h0,         32'h0,         0);
        run_op("jmp_top",   1, 0, 0, 0, 0, 0, 32'h0,         32'hFFFFFFFC,  32'h0,         0, 0, 32'hFFFFFFFC,  32'h0,         32'hFFFFFFFC,  0);
        run_op("wrap",      0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0);
        run_op("no_leak",   0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 32'h4,         32'h0,         32'h0,         0);
        run_op("jmp1000",   1, 0, 0, 0, 0, 0, 32'h0,         32'h1000,      32'h0,         0, 0, 32'h1000,      32'h0,         32'h1000,      0);
        run_op("jalr_odd",  1, 0, 0, 1, 0, 0, 32'h0,         32'hFFF,       32'h0,         0, 0, 32'h1FFE,      32'h0,         32'h1FFE,      1);
        run_op("jmp1000b",  1, 0, 0, 0, 0, 0, 32'h0,         32'h1000,      32'h0,         0, 0, 32'h1000,      32'h0,         32'h1000,      0);
        run_op("jalr_ok",   1, 0, 0, 1, 0, 0, 32'h0,         32'hFFC,       32'h0,         0, 0, 32'h1FFC,      32'h0,         32'h1FFC,      0);
        run_op("trap",      0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         32'h80000007,  0, 0, 32'h80000004,  32'h0,         32'h0,         0);
        run_op("jmp200",    1, 0, 0, 0, 0, 0, 32'h0,         32'h200,       32'h0,         0, 0, 32'h200,       32'h0,         32'h200,       0);
        run_op("jal",       1, 1, 0, 1, 0, 0, 32'h0,         32'h10,        32'h0,         0, 0, 32'h210,       32'h204,       32'h210,       0);
        run_op("jmp200b",   1, 0, 0, 0, 0, 0, 32'h0,         32'h200,       32'h0,         0, 0, 32'h200,       32'h0,         32'h200,       0);
        run_op("comp_link", 0, 1, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0,         0, 0, 32'h202,       32'h202,       32'h0,         0);
        run_op("lui",       0, 0, 1, 0, 0, 0, 32'h12345678,  32'h0,         32'h0,         0, 0, 32'h206,       32'h12345000,  32'h12345000,  0);
        run_op("hold_poke", 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         5, 1, 32'h20A,       32'h0,         32'h0,         0);

        // Reset in the middle of an update.
        @(negedge clk);
        jump = 0; jal = 0; utype = 0; pc_rel = 0; trap = 0; iscomp = 0; buf32 = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20 && beat4 != 3'd3; n++) @(negedge clk);
        chk("mid_beat", 32'(beat4), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_adr", adr4, RST_PC);
        chk("mid_rst_cyc", 32'(cyc4), 32'd0);
        chk("mid_rst_alt", alt_adr[0], RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_cyc", 32'(cyc4), 32'd1);
        chk("mid_rel_adr", adr4, RST_PC);
        wait_idle("mid");
        run_op("after_rst", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, RST_PC + 32'd4, 32'h0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
